// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: accepts one byte over valid/ready and serialises
// it as start bit, DATA_BITS data bits LSB first, stop bit.
module uart_tx_ctrl #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx_out,
    output logic                 busy,
    output logic                 tx_done
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] BAUD_TERM = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t               state, state_next;
    logic [CNT_W-1:0]     baud_cnt, baud_cnt_next;
    logic [IDX_W-1:0]     bit_idx, bit_idx_next;
    logic [DATA_BITS-1:0] shift_reg, shift_reg_next;
    logic                 tx_out_next, tx_ready_next, busy_next, tx_done_next;

    logic accept;
    logic baud_term;

    assign accept    = tx_valid && tx_ready && (state == IDLE);
    assign baud_term = (baud_cnt == BAUD_TERM);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx_out    <= 1'b1;
            tx_ready  <= 1'b1;
            busy      <= 1'b0;
            tx_done   <= 1'b0;
        end else begin
            baud_cnt  <= baud_cnt_next;
            bit_idx   <= bit_idx_next;
            shift_reg <= shift_reg_next;
            tx_out    <= tx_out_next;
            tx_ready  <= tx_ready_next;
            busy      <= busy_next;
            tx_done   <= tx_done_next;
        end
    end

    // Next-state logic: each bit state ends at the baud terminal count
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = START;
            START:   if (baud_term) state_next = DATA;
            DATA:    if (baud_term && (bit_idx == LAST_IDX)) state_next = STOP;
            STOP:    if (baud_term) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Next values for counters, shift register and outputs
    always_comb begin
        baud_cnt_next  = baud_cnt;
        bit_idx_next   = bit_idx;
        shift_reg_next = shift_reg;
        tx_out_next    = tx_out;
        tx_ready_next  = tx_ready;
        busy_next      = busy;
        tx_done_next   = 1'b0;
        case (state)
            IDLE: begin
                tx_out_next   = 1'b1;
                tx_ready_next = 1'b1;
                busy_next     = 1'b0;
                baud_cnt_next = '0;
                if (accept) begin
                    shift_reg_next = tx_data;
                    bit_idx_next   = '0;
                    tx_ready_next  = 1'b0;
                    busy_next      = 1'b1;
                    tx_out_next    = 1'b0;
                end
            end
            START: begin
                tx_out_next   = 1'b0;
                baud_cnt_next = baud_cnt + CNT_W'(1);
                if (baud_term) begin
                    baud_cnt_next = '0;
                    bit_idx_next  = '0;
                    tx_out_next   = shift_reg[0];
                end
            end
            DATA: begin
                tx_out_next   = shift_reg[0];
                baud_cnt_next = baud_cnt + CNT_W'(1);
                if (baud_term) begin
                    baud_cnt_next  = '0;
                    shift_reg_next = {1'b0, shift_reg[DATA_BITS-1:1]};
                    bit_idx_next   = bit_idx + IDX_W'(1);
                    tx_out_next    = (bit_idx == LAST_IDX) ? 1'b1 : shift_reg[1];
                end
            end
            STOP: begin
                tx_out_next   = 1'b1;
                baud_cnt_next = baud_cnt + CNT_W'(1);
                if (baud_term) begin
                    baud_cnt_next = '0;
                    tx_done_next  = 1'b1;
                    tx_ready_next = 1'b1;
                    busy_next     = 1'b0;
                end
            end
            default: begin
                baud_cnt_next = '0;
                bit_idx_next  = '0;
                tx_out_next   = 1'b1;
                tx_ready_next = 1'b1;
                busy_next     = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl with CLKS_PER_BIT=4, DATA_BITS=8.
module tb_uart_tx_ctrl;

    localparam int CPB = 4;
    localparam int NB  = 8;
    localparam int FRAME = (NB + 2) * CPB;

    logic          clk = 1'b0;
    logic          reset;
    logic [NB-1:0] tx_data;
    logic          tx_valid;
    logic          tx_ready, tx_out, busy, tx_done;

    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    bit rx_en = 1'b0;
    logic [8:0] rx_q[$];
    logic [7:0] exp_q[$];

    uart_tx_ctrl #(.CLKS_PER_BIT(CPB), .DATA_BITS(NB)) dut (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_out(tx_out), .busy(busy), .tx_done(tx_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (tx_done === 1'b1) done_cnt <= done_cnt + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference receiver: samples each bit in its middle
    initial begin
        logic [7:0] rb;
        forever begin
            @(negedge clk);
            if (rx_en && tx_out === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < NB; i++) begin
                    repeat (CPB) @(negedge clk);
                    rb[i] = tx_out;
                end
                repeat (CPB) @(negedge clk);
                rx_q.push_back({tx_out, rb});
            end
        end
    end

    // Send one frame and check every cycle of it; returns at the tx_done cycle
    task automatic tx_frame(input logic [7:0] b, input bit hold, input bit disturb,
                            input int abort_k, output time t_acc);
        int budget;
        logic exp_o;
        tx_data  = b;
        tx_valid = 1'b1;
        budget   = 0;
        while (tx_ready !== 1'b1 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        check("accept_wait", 32'(budget < 100), 32'd1);
        @(posedge clk);
        t_acc = $time;
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            if (k == 0 && !hold) tx_valid = 1'b0;
            if (disturb && k == 10) begin
                tx_data  = ~b;
                tx_valid = 1'b1;
            end
            if (disturb && k == 12) tx_valid = 1'b0;
            if (k == abort_k) begin
                reset    = 1'b1;
                tx_valid = 1'b0;
                #1;
                check("abort_tx_out", 32'(tx_out), 32'd1);
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_ready", 32'(tx_ready), 32'd1);
                check("abort_done", 32'(tx_done), 32'd0);
                return;
            end
            exp_o = (k < CPB) ? 1'b0 : (k >= (NB + 1) * CPB) ? 1'b1 : b[k / CPB - 1];
            check($sformatf("tx_out k=%0d", k), 32'(tx_out), 32'(exp_o));
            check($sformatf("busy k=%0d", k), 32'(busy), 32'd1);
            check($sformatf("ready k=%0d", k), 32'(tx_ready), 32'd0);
            check($sformatf("done k=%0d", k), 32'(tx_done), 32'd0);
        end
        @(negedge clk);
        check("end_done", 32'(tx_done), 32'd1);
        check("end_busy", 32'(busy), 32'd0);
        check("end_ready", 32'(tx_ready), 32'd1);
        check("end_tx_out", 32'(tx_out), 32'd1);
    endtask

    initial begin
        time t1, t2;
        int d0, budget;
        logic [7:0] b;
        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = '0;
        #1;
        check("rst_tx_out", 32'(tx_out), 32'd1);
        check("rst_ready", 32'(tx_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(tx_done), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // 1: idle after reset
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_tx_out", 32'(tx_out), 32'd1);
            check("idle_ready", 32'(tx_ready), 32'd1);
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_done", 32'(tx_done), 32'd0);
        end

        // 2: single frame 0xA5, single-cycle valid
        d0 = done_cnt;
        tx_frame(8'hA5, 1'b0, 1'b0, -1, t1);
        @(negedge clk);
        check("a5_done_once", 32'(tx_done), 32'd0);
        #1;
        check("a5_done_cnt", 32'(done_cnt - d0), 32'd1);

        // 3: back-to-back 0x00 then 0xFF with valid held
        tx_frame(8'h00, 1'b1, 1'b0, -1, t1);
        tx_frame(8'hFF, 1'b0, 1'b0, -1, t2);
        check("b2b_gap", 32'((t2 - t1) / 10), 32'(FRAME + 1));

        // 4: tx_data / tx_valid disturbed mid-frame
        repeat (3) @(negedge clk);
        tx_frame(8'h3C, 1'b0, 1'b1, -1, t1);
        tx_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("no_2nd_accept", 32'(busy), 32'd0);
        end

        // 5: reset during data bit 3 of 0x55, then 0x81
        d0 = done_cnt;
        tx_frame(8'h55, 1'b0, 1'b0, 4 * CPB + 1, t1);
        @(negedge clk);
        reset = 1'b0;
        repeat (50) @(negedge clk);
        #1;
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        @(negedge clk);
        tx_frame(8'h81, 1'b0, 1'b0, -1, t1);

        // 6: 256 random bytes through reference receiver
        repeat (3) @(negedge clk);
        rx_q.delete();
        rx_en = 1'b1;
        d0 = done_cnt;
        for (int i = 0; i < 256; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            tx_data  = b;
            tx_valid = 1'b1;
            budget   = 0;
            while (tx_ready !== 1'b1 && budget < 100) begin
                @(negedge clk);
                budget++;
            end
            @(posedge clk);
            @(negedge clk);
            tx_valid = 1'b0;
            budget   = 0;
            while (tx_done !== 1'b1 && budget < 100) begin
                @(negedge clk);
                budget++;
            end
            check("rand_done_wait", 32'(budget < 100), 32'd1);
        end
        repeat (3) @(negedge clk);
        #1;
        rx_en = 1'b0;
        check("rx_count", 32'(rx_q.size()), 32'd256);
        check("rand_done_cnt", 32'(done_cnt - d0), 32'd256);
        for (int i = 0; i < 256 && i < rx_q.size(); i++) begin
            check($sformatf("rx_byte %0d", i), 32'(rx_q[i][7:0]), 32'(exp_q[i]));
            check($sformatf("rx_stop %0d", i), 32'(rx_q[i][8]), 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
